// File: rtl/arc4_pkg.sv
// Shared ARC4 plaintext-check definitions: checker FSM states and default readable byte range.
package arc4_pkg;

    localparam logic [7:0] PT_LO_DEFAULT = 8'h20;
    localparam logic [7:0] PT_HI_DEFAULT = 8'h7E;

    typedef enum logic [1:0] {
        StIdle,
        StLen,
        StData,
        StFin
    } pt_state_e;

endpackage

// File: rtl/byte_readable.sv
// Combinational range test: flags a byte lying inside [LO,HI].
module byte_readable
    import arc4_pkg::*;
#(
    parameter logic [7:0] LO = PT_LO_DEFAULT,
    parameter logic [7:0] HI = PT_HI_DEFAULT
) (
    input  logic [7:0] data_i,
    output logic       readable_o
);

    assign readable_o = (data_i >= LO) && (data_i <= HI);

endmodule

// File: rtl/pt_check.sv
// Plaintext readability checker: stores a length-prefixed message to memory and reports
// whether every message byte is readable, with optional early abort on the first bad byte.
module pt_check
    import arc4_pkg::*;
#(
    parameter logic [7:0] LO          = PT_LO_DEFAULT,
    parameter logic [7:0] HI          = PT_HI_DEFAULT,
    parameter bit         EARLY_ABORT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       rdy,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output logic       done,
    output logic       pass,
    output logic       abort,
    output logic [7:0] bad_idx
);

    pt_state_e  state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] bad_q, bad_d;
    logic       pass_q, pass_d;
    logic       abort_q, abort_d;
    logic       xfer;
    logic       readable;
    logic [7:0] k;

    byte_readable #(
        .LO(LO),
        .HI(HI)
    ) u_readable (
        .data_i    (in_data),
        .readable_o(readable)
    );

    assign in_ready = (state_q == StLen) || (state_q == StData);
    assign xfer     = in_valid && in_ready;
    // k is the 1-based message index of the byte on the bus; at most 255, so no wrap.
    assign k        = cnt_q + 8'd1;

    assign pass     = pass_q;
    assign abort    = abort_q;
    assign bad_idx  = bad_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        bad_d     = bad_q;
        pass_d    = pass_q;
        abort_d   = 1'b0;
        rdy       = 1'b0;
        done      = 1'b0;
        pt_wren   = 1'b0;
        pt_addr   = 8'h00;
        pt_wrdata = 8'h00;

        unique case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    state_d = StLen;
                    pass_d  = 1'b0;
                    bad_d   = 8'h00;
                    cnt_d   = 8'h00;
                end
            end
            StLen: begin
                if (xfer) begin
                    pt_wren   = 1'b1;
                    pt_wrdata = in_data;
                    len_d     = in_data;
                    if (in_data == 8'h00) begin
                        state_d = StFin;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    pt_wren   = 1'b1;
                    pt_addr   = k;
                    pt_wrdata = in_data;
                    cnt_d     = k;
                    if (!readable && (bad_q == 8'h00)) begin
                        bad_d = k;
                    end
                    if ((!readable && EARLY_ABORT) || (k == len_q)) begin
                        state_d = StFin;
                        pass_d  = (bad_d == 8'h00);
                        abort_d = !readable && EARLY_ABORT;
                    end
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= 8'h00;
            cnt_q   <= 8'h00;
            bad_q   <= 8'h00;
            pass_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            pass_q  <= pass_d;
            abort_q <= abort_d;
        end
    end

endmodule

// File: doc/pt_check.md
PT_CHECK -- requirements
Module: pt_check

Interface
REQ-001 Parameter LO, default 8'h20, lowest byte value counted as readable plaintext.
REQ-002 Parameter HI, default 8'h7E, highest byte value counted as readable plaintext.
REQ-003 Parameter EARLY_ABORT, default 1, 1 = finish at the first unreadable byte; 0 = process the whole message.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  start request; accepted only while rdy=1.
REQ-007 rdy  out  1  high when idle and able to accept en.
REQ-008 in_valid  in  1  upstream ARC4 plaintext byte is valid.
REQ-009 in_data  in  8  plaintext byte; the first byte of each message is the length byte.
REQ-010 in_ready  out  1  block accepts in_data this cycle.
REQ-011 pt_addr  out  8  plaintext memory write address.
REQ-012 pt_wrdata  out  8  plaintext memory write data.
REQ-013 pt_wren  out  1  plaintext memory write enable.
REQ-014 done  out  1  one-cycle pulse when the verdict is final.
REQ-015 pass  out  1  verdict: 1 = every message byte is within [LO,HI]; held until the next accepted en.
REQ-016 abort  out  1  one-cycle pulse telling upstream to stop producing bytes (early abort only).
REQ-017 bad_idx  out  8  message index (1..len) of the first unreadable byte; 0 if none.

Function
REQ-018 A transfer shall occur on a cycle where in_valid=1 and in_ready=1; no other cycle shall consume in_data.
REQ-019 The block shall have states IDLE, LEN, DATA, FIN.
REQ-020 IDLE: rdy=1 and in_ready=0; en=1 moves to LEN, clears pass, bad_idx and the index counter.
REQ-021 LEN: in_ready=1; a transfer latches len and writes the byte to address 0 (pt_wren=1 that cycle).
REQ-022 LEN: the next state shall be DATA if len>0, otherwise FIN.
REQ-023 DATA: in_ready=1; the k-th transfer (k=1..len) shall write in_data to pt_addr=k in the same cycle.
REQ-024 DATA: a byte below LO or above HI shall mark the message failed; bad_idx takes the first such k only.
REQ-025 DATA: after transfer k=len the next state shall be FIN.
REQ-026 When EARLY_ABORT=1, a failing transfer shall still be written; the next state shall be FIN and abort shall pulse in the cycle the block enters FIN.
REQ-027 FIN: done=1 and pass=(no failure) for exactly one cycle, then IDLE; rdy=1 again one cycle after done.
REQ-028 Latency: done shall assert on the cycle after the final accepted byte, or after the failing byte under REQ-026.
REQ-029 en outside IDLE shall be ignored; in_valid while in_ready=0 shall be ignored with no write.
REQ-030 The index counter shall be 8 bits; len=255 shall write addresses 0..255 with no wrap before FIN.
REQ-031 pt_wren shall be 0 in every cycle without a transfer.

Reset
REQ-032 rst=1 at any clock edge shall force state IDLE regardless of the current state.
REQ-033 Reset values: rdy=1, in_ready=0, pt_wren=0, pt_addr=0, pt_wrdata=0, done=0, pass=0, abort=0, bad_idx=0.
REQ-034 A message interrupted by reset shall produce no done pulse; memory already written is not cleaned.

Structure
REQ-035 The state enum and default LO/HI constants shall live in the shared arc4_pkg.
REQ-036 There shall be a single sub-module, byte_readable, combinational: byte in, LO/HI parameters, in-range flag out.

Verification
REQ-037 len=3, bytes "abc" streamed back-to-back -> writes 0:03, 1:61, 2:62, 3:63; done and pass=1 one cycle after the 'c' transfer; bad_idx=0.
REQ-038 len=4, bytes 41,42,07,43 with EARLY_ABORT=1 -> byte 07 written at address 3; abort and done pulse next cycle; pass=0, bad_idx=3; the 43 byte is never accepted.
REQ-039 Same stream with EARLY_ABORT=0 -> all 4 bytes written; done after 43; pass=0, bad_idx=3.
REQ-040 len=0 -> single write 0:00; done and pass=1 on the next cycle.
REQ-041 Random in_valid gaps with len=5 -> writes only on transfer cycles, with addresses contiguous 0..5.
REQ-042 rst asserted mid-DATA after 2 of 5 bytes -> next cycle rdy=1, all outputs at reset values, no done pulse; a new en then runs a clean message.
